id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
Parametrised elastic ID/EX control pipeline stage that carries ALU control fields and a generic sideband from decode to execute. It has a valid/ready handshake and a 2-entry skid buffer, so that in_ready never combinationally depends on out_ready. It also supports a synchronous flush (branch mispredict / trap) and zeroes the output payload when no valid entry is presented, so EX sees a NOP bubble. A saturating backpressure-cycle counter feeds the perf monitors.

Parameters:
ALU_OP_WIDTH, 7, width of the ALU opcode field
ALU_FUNC3_WIDTH, 3, width of the func3 field
ALU_FUNC7_WIDTH, 7, width of the func7 field
SIDEBAND_WIDTH, 8, opaque payload carried alongside the controls (e.g. rd, tag); must be >= 1
STALL_CNT_WIDTH, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
flush  in  1  synchronous kill of all held entries
in_valid  in  1  decode presents an entry
in_ready  out  1  stage can accept an entry
reg_to_pc_in  in  1  operand A select: register or PC
alu_src_in  in  1  operand B select: register or immediate
alu_op_in  in  ALU_OP_WIDTH  ALU operation class
alu_func3_in  in  ALU_FUNC3_WIDTH  func3
alu_func7_in  in  ALU_FUNC7_WIDTH  func7
sideband_in  in  SIDEBAND_WIDTH  opaque payload
out_valid  out  1  entry presented to EX
out_ready  in  1  EX accepts the entry
reg_to_pc_out, alu_src_out, alu_op_out, alu_func3_out, alu_func7_out, sideband_out  out  matching widths  presented entry fields
stall_count  out  STALL_CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) and skid register. State is EMPTY, ONE or FULL.
- in_ready = (state != FULL) & ~flush. It comes from registered state and flush only, never from out_ready.
- out_valid = (state != EMPTY), registered.
- Output gating: when out_valid=0, all payload outputs are 0 (NOP bubble) regardless of register contents.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main <= input. Otherwise stay.
  - ONE:
    - in_fire & out_fire -> ONE, main <= input.
    - in_fire & ~out_fire -> FULL, skid <= input.
    - ~in_fire & out_fire -> EMPTY.
    - Neither -> stay; main is held.
  - FULL (in_ready=0): out_fire -> ONE, main <= skid. Otherwise hold.
- Flush: highest priority. Next state is EMPTY from any state. No input is accepted in the flush cycle. An out_fire in the flush cycle still counts as delivered to EX (EX handles its own kill). Next cycle: out_valid=0, in_ready=1.
- Latency: an entry accepted in cycle N into EMPTY appears with out_valid=1 in cycle N+1. Throughput is 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO. No entry is dropped or duplicated except by flush.
- stall_count:
  - Increments by 1 each cycle with out_valid & ~out_ready, including the flush cycle.
  - Saturates at 2^STALL_CNT_WIDTH-1.
  - Cleared only by reset.
- Reset (reset=0, asynchronous assert, synchronous-safe deassert): state EMPTY, both registers 0, stall_count 0. Outputs during reset: out_valid=0, all payload outputs 0, in_ready=1 (~flush), stall_count=0. Reset mid-transfer discards both entries.

Test Plan:
- Reset/bubble: hold reset=0 for 3 cycles with in_valid=1 and random payload. Expect out_valid=0, all outputs 0, stall_count=0. Release reset; the first accepted entry (alu_op=7'h33, func3=3'b000, func7=7'h20) appears on the next cycle.
- Streaming: out_ready=1, send 8 entries with sideband 0..7 back-to-back. Expect out_valid from cycle 1, sideband 0..7 in order on consecutive cycles, in_ready constantly 1, stall_count=0.
- Backpressure/skid: send A, B, C continuously with out_ready=0. Expect A accepted and presented, B into skid, in_ready=0 after B, C held at input. Raise out_ready; expect outputs A, B, C in order, no loss, and stall_count equal to the number of blocked cycles.
- Flush in FULL: fill to FULL, then assert flush for 1 cycle with in_valid=1. Next cycle: out_valid=0, outputs 0, in_ready=1. The input presented during the flush cycle is not accepted, and the next accepted entry is the first one after flush.
- Saturation: STALL_CNT_WIDTH=4, hold out_valid=1 and out_ready=0 for 20 cycles. Expect stall_count stops at 15.
- Async reset mid-operation: in FULL, drop reset between clock edges. Expect out_valid=0 and stall_count=0 immediately (before the next edge), and both entries gone after release.

Source files
------------

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: elastic ID/EX control pipeline stage with a 2-entry skid buffer.
// It carries the ALU control fields and an opaque sideband from decode to execute.
//   clk, reset (async, active-low)     : clock and reset
//   flush                              : synchronous kill of all held entries
//   in_valid / in_ready                : decode-side handshake
//   *_in                               : decode-side payload fields
//   out_valid / out_ready              : execute-side handshake
//   *_out                              : presented payload fields, zero when out_valid=0
//   stall_count                        : saturating count of out_valid & ~out_ready cycles
module id_ex_ctrl_stage #(
  parameter int unsigned ALU_OP_WIDTH    = 7,
  parameter int unsigned ALU_FUNC3_WIDTH = 3,
  parameter int unsigned ALU_FUNC7_WIDTH = 7,
  parameter int unsigned SIDEBAND_WIDTH  = 8,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       reg_to_pc_in,
  input  logic                       alu_src_in,
  input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
  input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
  input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
  input  logic [SIDEBAND_WIDTH-1:0]  sideband_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       reg_to_pc_out,
  output logic                       alu_src_out,
  output logic [ALU_OP_WIDTH-1:0]    alu_op_out,
  output logic [ALU_FUNC3_WIDTH-1:0] alu_func3_out,
  output logic [ALU_FUNC7_WIDTH-1:0] alu_func7_out,
  output logic [SIDEBAND_WIDTH-1:0]  sideband_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned PW = 2 + ALU_OP_WIDTH + ALU_FUNC3_WIDTH + ALU_FUNC7_WIDTH
                               + SIDEBAND_WIDTH;
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [PW-1:0]              main_q, main_d;
  logic [PW-1:0]              skid_q, skid_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic [PW-1:0]              in_data;
  logic                       in_fire;
  logic                       out_fire;

  assign in_data = {reg_to_pc_in, alu_src_in, alu_op_in, alu_func3_in, alu_func7_in,
                    sideband_in};

  // Handshake derived from registered state (and flush) only, never from out_ready.
  assign in_ready  = (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // NOP bubble: payload forced to zero whenever nothing is presented.
  assign {reg_to_pc_out, alu_src_out, alu_op_out, alu_func3_out, alu_func7_out,
          sideband_out} = out_valid ? main_q : '0;

  assign stall_count = stall_q;

  // State and storage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Saturating backpressure counter; counts in the flush cycle as well.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage: directed bench for id_ex_ctrl_stage. A second instance with a
// 4-bit stall counter shares the stimulus to exercise counter saturation.
module tb_id_ex_ctrl_stage;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic       reg_to_pc_in;
  logic       alu_src_in;
  logic [6:0] alu_op_in;
  logic [2:0] alu_func3_in;
  logic [6:0] alu_func7_in;
  logic [7:0] sideband_in;
  logic       out_valid;
  logic       out_ready;
  logic       reg_to_pc_out;
  logic       alu_src_out;
  logic [6:0] alu_op_out;
  logic [2:0] alu_func3_out;
  logic [6:0] alu_func7_out;
  logic [7:0] sideband_out;
  logic [15:0] stall_count;

  logic        s_in_ready, s_out_valid, s_reg_to_pc, s_alu_src;
  logic [6:0]  s_alu_op, s_alu_func7;
  logic [2:0]  s_alu_func3;
  logic [7:0]  s_sideband;
  logic [3:0]  s_stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_ctrl_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg_to_pc_in(reg_to_pc_in), .alu_src_in(alu_src_in), .alu_op_in(alu_op_in),
    .alu_func3_in(alu_func3_in), .alu_func7_in(alu_func7_in), .sideband_in(sideband_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_to_pc_out(reg_to_pc_out), .alu_src_out(alu_src_out), .alu_op_out(alu_op_out),
    .alu_func3_out(alu_func3_out), .alu_func7_out(alu_func7_out),
    .sideband_out(sideband_out), .stall_count(stall_count)
  );

  id_ex_ctrl_stage #(.STALL_CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .reg_to_pc_in(reg_to_pc_in), .alu_src_in(alu_src_in), .alu_op_in(alu_op_in),
    .alu_func3_in(alu_func3_in), .alu_func7_in(alu_func7_in), .sideband_in(sideband_in),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .reg_to_pc_out(s_reg_to_pc), .alu_src_out(s_alu_src), .alu_op_out(s_alu_op),
    .alu_func3_out(s_alu_func3), .alu_func7_out(s_alu_func7),
    .sideband_out(s_sideband), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [7:0] sb);
    in_valid     = v;
    sideband_in  = sb;
    reg_to_pc_in = sb[0];
    alu_src_in   = sb[1];
    alu_op_in    = 7'h13;
    alu_func3_in = 3'b101;
    alu_func7_in = 7'h01;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    present(1'b1, 8'($urandom));
    alu_op_in = 7'($urandom); alu_func7_in = 7'($urandom);

    // Reset with live input: bubble outputs.
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sideband", 64'(sideband_out), 64'd0);
    check("rst_alu_op", 64'({alu_op_out, alu_func3_out, alu_func7_out}), 64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // First entry after release appears one cycle later.
    reset = 1'b1;
    in_valid = 1'b1; alu_op_in = 7'h33; alu_func3_in = 3'b000; alu_func7_in = 7'h20;
    sideband_in = 8'hA5;
    #1 check("first_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_fields", 64'({alu_op_out, alu_func3_out, alu_func7_out}),
          64'({7'h33, 3'b000, 7'h20}));
    check("first_sideband", 64'(sideband_out), 64'hA5);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("first_drain", 64'(out_valid), 64'd0);
    check("first_stall", 64'(stall_count), 64'd0);

    // Streaming at full throughput.
    for (int i = 0; i < 8; i++) begin
      present(1'b1, 8'(i));
      #1 check("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_sideband", 64'(sideband_out), 64'(i));
      check("stream_sel", 64'({reg_to_pc_out, alu_src_out}), 64'({i[0], i[1]}));
    end
    present(1'b0, 8'h00);
    tick();
    check("stream_end_valid", 64'(out_valid), 64'd0);
    check("stream_stall", 64'(stall_count), 64'd0);

    // Backpressure into the skid register.
    out_ready = 1'b0;
    present(1'b1, 8'd10);
    tick();
    check("bp_a_out", 64'(sideband_out), 64'd10);
    present(1'b1, 8'd11);
    #1 check("bp_b_ready", 64'(in_ready), 64'd1);
    tick();
    present(1'b1, 8'd12);
    #1 check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_out", 64'(sideband_out), 64'd10);
    check("bp_stall1", 64'(stall_count), 64'd1);
    tick();
    tick();
    check("bp_stall3", 64'(stall_count), 64'd3);
    check("bp_hold_out", 64'(sideband_out), 64'd10);
    out_ready = 1'b1;
    tick();
    check("bp_out_b", 64'(sideband_out), 64'd11);
    check("bp_ready_again", 64'(in_ready), 64'd1);
    tick();
    check("bp_out_c", 64'(sideband_out), 64'd12);
    present(1'b0, 8'h00);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_stall_final", 64'(stall_count), 64'd3);

    // Flush while FULL.
    out_ready = 1'b0;
    present(1'b1, 8'd20);
    tick();
    present(1'b1, 8'd21);
    tick();
    present(1'b1, 8'd22);
    flush = 1'b1;
    #1 check("fl_ready_in_flush", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    present(1'b0, 8'h00);
    #1 check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_sideband", 64'(sideband_out), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_stall", 64'(stall_count), 64'd5);
    present(1'b1, 8'd23);
    out_ready = 1'b1;
    tick();
    check("fl_next_entry", 64'(sideband_out), 64'd23);
    present(1'b0, 8'h00);
    tick();
    check("fl_after_valid", 64'(out_valid), 64'd0);

    // Saturation of the 4-bit counter (starts at 5 like the wide one).
    out_ready = 1'b0;
    present(1'b1, 8'd30);
    tick();
    present(1'b0, 8'h00);
    check("sat_start", 64'(s_stall_count), 64'd5);
    repeat (9) tick();
    check("sat_14", 64'(s_stall_count), 64'd14);
    repeat (11) tick();
    check("sat_15", 64'(s_stall_count), 64'd15);
    check("sat_wide", 64'(stall_count), 64'd25);
    check("sat_valid", 64'(s_out_valid), 64'd1);

    // Asynchronous reset while FULL.
    present(1'b1, 8'd31);
    tick();
    present(1'b0, 8'h00);
    check("ar_full_ready", 64'(in_ready), 64'd0);
    #2 reset = 1'b0;
    #1 check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_stall", 64'(stall_count), 64'd0);
    check("ar_sideband", 64'(sideband_out), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar_gone", 64'(out_valid), 64'd0);
    present(1'b1, 8'd40);
    tick();
    check("ar_new_entry", 64'(sideband_out), 64'd40);
    present(1'b0, 8'h00);
    tick();
    check("ar_new_drain", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
